// File: rtl/telemetry_uart_tx_if.sv
// telemetry_uart_tx_if: snapshot inputs, frame triggers and UART/status outputs of the telemetry transmitter.
interface telemetry_uart_tx_if;
    logic        enable;
    logic        send_now;
    logic [15:0] dist_left;
    logic [15:0] dist_right;
    logic [15:0] dist_front;
    logic [1:0]  end_signal;
    logic [19:0] cnt_left;
    logic [19:0] cnt_right;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    modport master (
        output enable, send_now, dist_left, dist_right, dist_front, end_signal, cnt_left, cnt_right,
        input  tx, busy, frame_done, overrun
    );
    modport slave (
        input  enable, send_now, dist_left, dist_right, dist_front, end_signal, cnt_left, cnt_right,
        output tx, busy, frame_done, overrun
    );
endinterface

// File: rtl/telemetry_uart_tx.sv
// telemetry_uart_tx: periodic snapshot of distances/end code, framed with XOR checksum and sent 8N1.
// Define TELEM_ENC_EN to append the two 20-bit encoder counts (15-byte frame instead of 9).
module telemetry_uart_tx #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int PERIOD_CYCLES = 5_000_000
) (
    input logic               clk_50M,
    input logic               reset,
    telemetry_uart_tx_if.slave bus
);
`ifdef TELEM_ENC_EN
    localparam int NB = 15;
`else
    localparam int NB = 9;
`endif
    localparam int FW = NB * 8;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [PW-1:0]       per_q;
    logic [CW-1:0]       clk_q, clk_d;
    logic [2:0]          bit_q, bit_d;
    logic [3:0]          idx_q, idx_d;
    logic [FW-1:0]       frame_q, frame_d, snap;
    logic [8*(NB-2)-1:0] payload;
    logic [7:0]          chk;
    logic                overrun_q;
    logic                expiry, bit_end, last_byte;

    assign expiry    = per_q == PW'(PERIOD_CYCLES - 1);
    assign bit_end   = clk_q == CW'(CLKS_PER_BIT - 1);
    assign last_byte = idx_q == 4'(NB - 1);

`ifdef TELEM_ENC_EN
    assign payload = {bus.dist_left, bus.dist_right, bus.dist_front, 4'b0, bus.cnt_left,
                      4'b0, bus.cnt_right, 6'b0, bus.end_signal};
`else
    logic unused_cnt;
    assign unused_cnt = ^{bus.cnt_left, bus.cnt_right};
    assign payload    = {bus.dist_left, bus.dist_right, bus.dist_front, 6'b0, bus.end_signal};
`endif

    always_comb begin
        chk = '0;
        for (int i = 0; i < NB - 2; i++) chk ^= payload[8*i +: 8];
    end

    // Header occupies the top byte; the frame register shifts up one byte per stop bit.
    assign snap = {8'hA5, payload, chk};

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        clk_d   = (state_q == IDLE || state_q == LOAD || bit_end) ? '0 : clk_q + 1'b1;
        case (state_q)
            IDLE:  state_d = (bus.enable && (expiry || bus.send_now)) ? LOAD : IDLE;
            LOAD: begin
                state_d = START;
                frame_d = snap;
                idx_d   = '0;
            end
            START: if (bit_end) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (bit_end) begin
                bit_d   = bit_q + 1'b1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (bit_end) begin
                state_d = last_byte ? IDLE : START;
                idx_d   = idx_q + 1'b1;
                frame_d = frame_q << 8;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            per_q     <= '0;
            clk_q     <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= expiry ? '0 : per_q + 1'b1;
            clk_q     <= clk_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            overrun_q <= overrun_q | (bus.enable && expiry && state_q != IDLE);
        end
    end

    // Outputs decode straight from state so an async reset forces the line idle at once.
    assign bus.tx         = state_q == START ? 1'b0 : state_q == DATA ? frame_q[FW - 8 + int'(bit_q)] : 1'b1;
    assign bus.busy       = state_q != IDLE;
    assign bus.frame_done = state_q == STOP && bit_end && last_byte;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_telemetry_uart_tx.sv
// tb_telemetry_uart_tx: directed frame, snapshot, overrun and mid-frame reset checks (CLKS_PER_BIT=4, PERIOD_CYCLES=500).
module tb_telemetry_uart_tx;
    localparam int CPB = 4;
    localparam int BT  = 10 * CPB;
`ifdef TELEM_ENC_EN
    localparam int NB = 15;
`else
    localparam int NB = 9;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         tests = 0, fails = 0, cyc = 0, t_load = 0, fd_off = -1;
    logic [7:0] rx [15];
    logic [7:0] exp [15];
    logic       txs [0:BT*15+1];
    bit         got, framed, b_last, b_after;

    telemetry_uart_tx_if bus ();

    telemetry_uart_tx #(.CLKS_PER_BIT(CPB), .PERIOD_CYCLES(500)) dut (
        .clk_50M(clk),
        .reset  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_in(input logic [15:0] dl, dr, df, input logic [1:0] e, input logic [19:0] cl, cr);
        logic [7:0] c;
        int n;
        n = 7;
        bus.dist_left = dl; bus.dist_right = dr; bus.dist_front = df;
        bus.end_signal = e; bus.cnt_left = cl; bus.cnt_right = cr;
        exp[0] = 8'hA5; exp[1] = dl[15:8]; exp[2] = dl[7:0]; exp[3] = dr[15:8];
        exp[4] = dr[7:0]; exp[5] = df[15:8]; exp[6] = df[7:0];
`ifdef TELEM_ENC_EN
        exp[7] = {4'b0, cl[19:16]}; exp[8] = cl[15:8]; exp[9] = cl[7:0];
        exp[10] = {4'b0, cr[19:16]}; exp[11] = cr[15:8]; exp[12] = cr[7:0];
        n = 13;
`endif
        exp[n] = {6'b0, e};
        c = '0;
        for (int i = 1; i <= n; i++) c ^= exp[i];
        exp[n+1] = c;
    endtask

    task automatic pulse_send(input bit keep_en);
        @(negedge clk);
        bus.enable = 1'b1;
        bus.send_now = 1'b1;
        @(negedge clk);
        bus.send_now = 1'b0;
        if (!keep_en) bus.enable = 1'b0;
    endtask

    // Waits (bounded) for busy, then records tx for every cycle of the frame and decodes it.
    task automatic recv(input bit scramble);
        got = 1'b0; framed = 1'b1; fd_off = -1;
        for (int i = 0; i < 1200 && !got; i++) begin
            if (bus.busy) got = 1'b1;
            else @(negedge clk);
        end
        t_load = cyc;
        if (!got) return;
        for (int off = 1; off <= BT*NB + 1; off++) begin
            @(negedge clk);
            if (scramble && off == 1) begin
                bus.dist_left = ~bus.dist_left; bus.dist_right = ~bus.dist_right;
                bus.dist_front = ~bus.dist_front; bus.end_signal = ~bus.end_signal;
                bus.cnt_left = ~bus.cnt_left; bus.cnt_right = ~bus.cnt_right;
                bus.enable = 1'b0; bus.send_now = 1'b1;
            end
            if (scramble && off == 2) bus.send_now = 1'b0;
            txs[off] = bus.tx;
            if (bus.frame_done && fd_off < 0) fd_off = off;
            if (off == BT*NB) b_last = bus.busy;
            if (off == BT*NB + 1) b_after = bus.busy;
        end
        for (int k = 0; k < NB; k++) begin
            if (txs[1 + BT*k + CPB/2] !== 1'b0 || txs[1 + BT*k + 9*CPB + CPB/2] !== 1'b1) framed = 1'b0;
            for (int b = 0; b < 8; b++) rx[k][b] = txs[1 + BT*k + CPB*(1+b) + CPB/2];
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        bus.enable = 1'b0; bus.send_now = 1'b0;
        set_in(16'h0, 16'h0, 16'h0, 2'b00, 20'h0, 20'h0);
        #12;
        tests++; if (bus.tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", bus.tx); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
        tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL disabled_idle: got %0d bad cycles expected 0", bad); end
        tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL disabled_overrun: got %b expected 0", bus.overrun); end
    endtask

    task automatic test_frame();
        set_in(16'h0123, 16'h4567, 16'h89AB, 2'b10, 20'h0, 20'h0);
        pulse_send(1'b0);
        recv(1'b0);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL frame_start: got busy=%b expected 1", got); end
        tests++; if (txs[1] !== 1'b0) begin fails++; $display("FAIL frame_tx_low_after_load: got %b expected 0", txs[1]); end
        tests++; if (framed !== 1'b1) begin fails++; $display("FAIL frame_start_stop_bits: got %b expected 1", framed); end
        tests++; if (fd_off !== BT*NB) begin fails++; $display("FAIL frame_done_offset: got %0d expected %0d", fd_off, BT*NB); end
        tests++; if (b_last !== 1'b1) begin fails++; $display("FAIL busy_last_stop: got %b expected 1", b_last); end
        tests++; if (b_after !== 1'b0) begin fails++; $display("FAIL busy_after_frame: got %b expected 0", b_after); end
        for (int k = 0; k < NB; k++) begin
            tests++; if (rx[k] !== exp[k]) begin fails++; $display("FAIL frame_byte%0d: got %h expected %h", k, rx[k], exp[k]); end
        end
        tests++; if (rx[NB-1] !== 8'h20) begin fails++; $display("FAIL frame_chk: got %h expected 20", rx[NB-1]); end
    endtask

    task automatic test_snapshot();
        set_in(16'h0123, 16'h4567, 16'h89AB, 2'b10, 20'h0, 20'h0);
        pulse_send(1'b0);
        recv(1'b1);
        tests++; if (got !== 1'b1 || framed !== 1'b1) begin fails++; $display("FAIL snap_framing: got %b%b expected 11", got, framed); end
        for (int k = 0; k < NB; k++) begin
            tests++; if (rx[k] !== exp[k]) begin fails++; $display("FAIL snap_byte%0d: got %h expected %h", k, rx[k], exp[k]); end
        end
        tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL snap_overrun: got %b expected 0", bus.overrun); end
    endtask

    task automatic test_overrun();
        int t1;
        set_in(16'h1111, 16'h2222, 16'h3333, 2'b01, 20'h0, 20'h0);
        @(negedge clk);
        bus.enable = 1'b1;
        recv(1'b0);
        t1 = t_load;
        tests++; if (got !== 1'b1 || rx[NB-1] !== exp[NB-1]) begin fails++; $display("FAIL expiry_frame: got %b/%h expected 1/%h", got, rx[NB-1], exp[NB-1]); end
        while (cyc < t1 + 400) @(negedge clk);
        bus.send_now = 1'b1;
        @(negedge clk);
        bus.send_now = 1'b0;
        recv(1'b0);
        tests++; if (t_load !== t1 + 401) begin fails++; $display("FAIL send_now_load: got %0d expected %0d", t_load - t1, 401); end
        tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
        set_in(16'hBEEF, 16'h0042, 16'h7001, 2'b11, 20'h0, 20'h0);
        recv(1'b0);
        tests++; if (t_load !== t1 + 1000) begin fails++; $display("FAIL next_expiry_load: got %0d expected 1000", t_load - t1); end
        tests++; if (framed !== 1'b1) begin fails++; $display("FAIL after_overrun_framing: got %b expected 1", framed); end
        for (int k = 0; k < NB; k++) begin
            tests++; if (rx[k] !== exp[k]) begin fails++; $display("FAIL after_overrun_byte%0d: got %h expected %h", k, rx[k], exp[k]); end
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_in(16'hAAAA, 16'h0055, 16'h0F0F, 2'b11, 20'h0, 20'h0);
        pulse_send(1'b0);
        got = 1'b0;
        for (int i = 0; i < 1200 && !got; i++) begin
            if (bus.busy) got = 1'b1;
            else @(negedge clk);
        end
        repeat (130) @(negedge clk);
        tests++; if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL pre_reset_data: got tx=%b busy=%b expected 0/1", bus.tx, bus.busy); end
        #1 rst_n = 1'b0;
        #1;
        tests++; if (bus.tx !== 1'b1) begin fails++; $display("FAIL async_reset_tx: got %b expected 1", bus.tx); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL async_reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL async_reset_overrun: got %b expected 0", bus.overrun); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_in(16'h0123, 16'h4567, 16'h89AB, 2'b10, 20'h0, 20'h0);
        pulse_send(1'b0);
        recv(1'b0);
        tests++; if (got !== 1'b1 || framed !== 1'b1) begin fails++; $display("FAIL post_reset_framing: got %b%b expected 11", got, framed); end
        for (int k = 0; k < NB; k++) begin
            tests++; if (rx[k] !== exp[k]) begin fails++; $display("FAIL post_reset_byte%0d: got %h expected %h", k, rx[k], exp[k]); end
        end
    endtask

`ifdef TELEM_ENC_EN
    task automatic test_encoder();
        set_in(16'h0123, 16'h4567, 16'h89AB, 2'b10, 20'hABCDE, 20'h00001);
        pulse_send(1'b0);
        recv(1'b0);
        tests++; if (got !== 1'b1 || framed !== 1'b1) begin fails++; $display("FAIL enc_framing: got %b%b expected 11", got, framed); end
        for (int k = 0; k < NB; k++) begin
            tests++; if (rx[k] !== exp[k]) begin fails++; $display("FAIL enc_byte%0d: got %h expected %h", k, rx[k], exp[k]); end
        end
        tests++; if (rx[14] !== 8'h49) begin fails++; $display("FAIL enc_chk: got %h expected 49", rx[14]); end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_snapshot();
        test_overrun();
        test_reset_mid();
`ifdef TELEM_ENC_EN
        test_encoder();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
